// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache port between SQ head-store retire and load issue, one transaction at a time.
// Build option: define DCACHE_ARB_PERF_EN to add load/store/promotion performance counters.
module dcache_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int TAG_W        = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clock,
   input  logic             reset,

   input  logic             st_req_valid,
   input  logic [XLEN-1:0]  st_req_addr,
   input  logic [XLEN-1:0]  st_req_data,
   input  logic [1:0]       st_req_size,
   output logic             st_req_ready,

   input  logic             ld_req_valid,
   input  logic [XLEN-1:0]  ld_req_addr,
   input  logic [1:0]       ld_req_size,
   input  logic             ld_req_signed,
   input  logic [TAG_W-1:0] ld_req_tag,
   output logic             ld_req_ready,

   output logic             cache_req_valid,
   output logic             cache_req_wr,
   output logic [XLEN-1:0]  cache_req_addr,
   output logic [XLEN-1:0]  cache_req_data,
   output logic [1:0]       cache_req_size,
   input  logic             cache_req_ready,
   input  logic             cache_resp_valid,
   input  logic [XLEN-1:0]  cache_resp_data,

   output logic             ld_resp_valid,
   output logic [XLEN-1:0]  ld_resp_data,
   output logic [TAG_W-1:0] ld_resp_tag,
   output logic             st_done,
`ifdef DCACHE_ARB_PERF_EN
   output logic [31:0]      perf_ld_cnt,
   output logic [31:0]      perf_st_cnt,
   output logic [31:0]      perf_promote_cnt,
`endif
   input  logic             flush
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
   localparam logic [3:0] STARVE_MAX = 4'hF;

   state_t             state;
   logic [3:0]         starve_cnt;
   logic               squash;

   logic               req_wr;
   logic [XLEN-1:0]    req_addr;
   logic [XLEN-1:0]    req_data;
   logic [1:0]         req_size;
   logic               req_signed;
   logic [TAG_W-1:0]   req_tag;

   logic               idle;
   logic               ld_avail;
   logic               st_wins;
   logic               grant_st;
   logic               grant_ld;

   // A load is invisible to arbitration while a squash is in flight, so a waiting store takes the slot.
   assign idle     = (state == S_IDLE);
   assign ld_avail = ld_req_valid && !flush;
   assign st_wins  = st_req_valid && (!ld_avail || (starve_cnt >= STARVE_LIM));
   assign grant_st = idle && st_wins;
   assign grant_ld = idle && ld_avail && !st_wins;

   assign st_req_ready = grant_st;
   assign ld_req_ready = grant_ld;

   assign cache_req_wr   = req_wr;
   assign cache_req_addr = req_addr;
   assign cache_req_data = req_data;
   assign cache_req_size = req_size;

   // Pick the addressed byte/half out of the aligned word and extend it to XLEN.
   function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                               input logic [1:0]      lane,
                                               input logic [1:0]      size,
                                               input logic            sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: extract = {{(XLEN-8){sgn & b[7]}}, b};
         SZ_HALF: extract = {{(XLEN-16){sgn & h[15]}}, h};
         default: extract = word;
      endcase
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_IDLE;
         starve_cnt      <= '0;
         squash          <= 1'b0;
         req_wr          <= 1'b0;
         req_addr        <= '0;
         req_data        <= '0;
         req_size        <= '0;
         req_signed      <= 1'b0;
         req_tag         <= '0;
         cache_req_valid <= 1'b0;
         ld_resp_valid   <= 1'b0;
         ld_resp_data    <= '0;
         ld_resp_tag     <= '0;
         st_done         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every decision below sees pre-edge state
         // and a later assignment in the same cycle (e.g. squash clear) cleanly overrides an earlier one.
         ld_resp_valid <= 1'b0;
         st_done       <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_st || grant_ld) begin
                  req_wr          <= grant_st;
                  req_addr        <= grant_st ? st_req_addr : ld_req_addr;
                  req_data        <= grant_st ? st_req_data : '0;
                  req_size        <= grant_st ? st_req_size : ld_req_size;
                  req_signed      <= grant_ld && ld_req_signed;
                  req_tag         <= grant_ld ? ld_req_tag : '0;
                  cache_req_valid <= 1'b1;
                  state           <= S_ISSUE;
               end
               if (grant_st) begin
                  starve_cnt <= '0;
               end else if (grant_ld && st_req_valid && (starve_cnt != STARVE_MAX)) begin
                  starve_cnt <= starve_cnt + 4'd1;
               end
            end

            S_ISSUE: begin
               if (flush && !req_wr) begin
                  squash <= 1'b1;
               end
               if (cache_req_ready) begin
                  cache_req_valid <= 1'b0;
                  state           <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (flush && !req_wr) begin
                  squash <= 1'b1;
               end
               if (cache_resp_valid) begin
                  state  <= S_IDLE;
                  squash <= 1'b0;
                  if (req_wr) begin
                     st_done <= 1'b1;
                  end else if (!(squash || flush)) begin
                     ld_resp_valid <= 1'b1;
                     ld_resp_data  <= extract(cache_resp_data, req_addr[1:0], req_size, req_signed);
                     ld_resp_tag   <= req_tag;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_ARB_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_ld_cnt      <= '0;
         perf_st_cnt      <= '0;
         perf_promote_cnt <= '0;
      end else begin
         if (grant_ld) begin
            perf_ld_cnt <= perf_ld_cnt + 32'd1;
         end
         if (grant_st) begin
            perf_st_cnt <= perf_st_cnt + 32'd1;
         end
         if (grant_st && ld_avail) begin
            perf_promote_cnt <= perf_promote_cnt + 32'd1;
         end
      end
   end
`endif

   // Handshake invariants: grants are exclusive, and a stalled request holds its fields.
   a_excl_grant : assert property (@(posedge clock) disable iff (reset)
      !(st_req_ready && ld_req_ready));

   a_req_stable : assert property (@(posedge clock) disable iff (reset)
      (cache_req_valid && !cache_req_ready) |=>
         (cache_req_valid && $stable(cache_req_addr) && $stable(cache_req_data)
          && $stable(cache_req_wr) && $stable(cache_req_size)));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: load vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_dcache_port_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int RAND_CYCLES  = 3000;

   logic        clock = 1'b0;
   logic        reset;
   logic        st_req_valid;
   logic [31:0] st_req_addr;
   logic [31:0] st_req_data;
   logic [1:0]  st_req_size;
   logic        st_req_ready;
   logic        ld_req_valid;
   logic [31:0] ld_req_addr;
   logic [1:0]  ld_req_size;
   logic        ld_req_signed;
   logic [4:0]  ld_req_tag;
   logic        ld_req_ready;
   logic        cache_req_valid;
   logic        cache_req_wr;
   logic [31:0] cache_req_addr;
   logic [31:0] cache_req_data;
   logic [1:0]  cache_req_size;
   logic        cache_req_ready;
   logic        cache_resp_valid;
   logic [31:0] cache_resp_data;
   logic        ld_resp_valid;
   logic [31:0] ld_resp_data;
   logic [4:0]  ld_resp_tag;
   logic        st_done;
   logic        flush;
`ifdef DCACHE_ARB_PERF_EN
   logic [31:0] perf_ld_cnt;
   logic [31:0] perf_st_cnt;
   logic [31:0] perf_promote_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   dcache_port_arbiter #(
      .XLEN(32),
      .TAG_W(5),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .st_req_valid(st_req_valid),
      .st_req_addr(st_req_addr),
      .st_req_data(st_req_data),
      .st_req_size(st_req_size),
      .st_req_ready(st_req_ready),
      .ld_req_valid(ld_req_valid),
      .ld_req_addr(ld_req_addr),
      .ld_req_size(ld_req_size),
      .ld_req_signed(ld_req_signed),
      .ld_req_tag(ld_req_tag),
      .ld_req_ready(ld_req_ready),
      .cache_req_valid(cache_req_valid),
      .cache_req_wr(cache_req_wr),
      .cache_req_addr(cache_req_addr),
      .cache_req_data(cache_req_data),
      .cache_req_size(cache_req_size),
      .cache_req_ready(cache_req_ready),
      .cache_resp_valid(cache_resp_valid),
      .cache_resp_data(cache_resp_data),
      .ld_resp_valid(ld_resp_valid),
      .ld_resp_data(ld_resp_data),
      .ld_resp_tag(ld_resp_tag),
      .st_done(st_done),
`ifdef DCACHE_ARB_PERF_EN
      .perf_ld_cnt(perf_ld_cnt),
      .perf_st_cnt(perf_st_cnt),
      .perf_promote_cnt(perf_promote_cnt),
`endif
      .flush(flush)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] resp;
      logic [31:0] exp;
   } ld_vec_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      bit          sgn;
      logic [4:0]  tag;
   } txn_t;

   ld_vec_t vecs [9];

   // Reference model state for the random phase.
   bit          m_out;
   bit          m_sent;
   bit          m_sq;
   int          m_starve;
   txn_t        m_txn;
   bit          ld_ok;
   bit          st_win;
   bit          e_st_rdy;
   bit          e_ld_rdy;
   bit          e_crv;
   bit          e_ldv;
   bit          e_std;
   logic [31:0] e_ldd;
   logic [4:0]  e_ldt;
   int          sz;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] model_extract(input logic [31:0] word, input logic [31:0] addr,
                                                 input logic [1:0] size, input bit sgn);
      int          nbits;
      int          shift;
      logic [63:0] mask;
      logic [63:0] v;
      nbits = 8 << size;
      shift = (size == 2'd2) ? 0 : (int'(addr % 32'd4) / (nbits / 8)) * nbits;
      mask  = (64'd1 << nbits) - 64'd1;
      v     = ({32'b0, word} >> shift) & mask;
      if (sgn && v[nbits-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   // Single load with fastest cache: grant T, request T+1, response T+2, result T+3.
   task automatic do_load(input ld_vec_t v, input logic [4:0] tag, input string nm);
      ld_req_valid  = 1'b1;
      ld_req_addr   = v.addr;
      ld_req_size   = v.size;
      ld_req_signed = v.sgn;
      ld_req_tag    = tag;
      #1;
      check($sformatf("%s.ld_ready", nm), ld_req_ready, 1);
      check($sformatf("%s.st_ready", nm), st_req_ready, 0);
      tick();
      ld_req_valid = 1'b0;
      #1;
      check($sformatf("%s.req_valid", nm), cache_req_valid, 1);
      check($sformatf("%s.req_wr", nm), cache_req_wr, 0);
      check($sformatf("%s.req_addr", nm), cache_req_addr, v.addr);
      check($sformatf("%s.req_size", nm), cache_req_size, v.size);
      cache_req_ready = 1'b1;
      tick();
      cache_req_ready  = 1'b0;
      cache_resp_valid = 1'b1;
      cache_resp_data  = v.resp;
      #1;
      check($sformatf("%s.early_resp", nm), ld_resp_valid, 0);
      tick();
      cache_resp_valid = 1'b0;
      #1;
      check($sformatf("%s.resp_valid", nm), ld_resp_valid, 1);
      check($sformatf("%s.resp_data", nm), ld_resp_data, v.exp);
      check($sformatf("%s.resp_tag", nm), ld_resp_tag, tag);
      tick();
      check($sformatf("%s.pulse_end", nm), ld_resp_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{32'h0000_1003, 2'd0, 1'b1, 32'h80FF_FF00, 32'hFFFF_FF80};
      vecs[1] = '{32'h0000_3002, 2'd1, 1'b0, 32'hABCD_1234, 32'h0000_ABCD};
      vecs[2] = '{32'h0000_1001, 2'd0, 1'b0, 32'h1234_5678, 32'h0000_0056};
      vecs[3] = '{32'h0000_4000, 2'd1, 1'b1, 32'h0000_8001, 32'hFFFF_8001};
      vecs[4] = '{32'h0000_5000, 2'd2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[5] = '{32'h0000_6000, 2'd0, 1'b1, 32'h1234_567F, 32'h0000_007F};
      vecs[6] = '{32'h0000_6002, 2'd0, 1'b0, 32'h00FF_0000, 32'h0000_00FF};
      vecs[7] = '{32'h0000_7002, 2'd1, 1'b1, 32'h7FFF_0000, 32'h0000_7FFF};
      vecs[8] = '{32'h0000_7002, 2'd1, 1'b1, 32'hFFFE_0000, 32'hFFFF_FFFE};

      reset            = 1'b1;
      st_req_valid     = 1'b0;
      st_req_addr      = '0;
      st_req_data      = '0;
      st_req_size      = '0;
      ld_req_valid     = 1'b0;
      ld_req_addr      = '0;
      ld_req_size      = '0;
      ld_req_signed    = 1'b0;
      ld_req_tag       = '0;
      cache_req_ready  = 1'b0;
      cache_resp_valid = 1'b0;
      cache_resp_data  = '0;
      flush            = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("rst.req_valid", cache_req_valid, 0);
      check("rst.ld_resp_valid", ld_resp_valid, 0);
      check("rst.st_done", st_done, 0);
      check("rst.ld_resp_data", ld_resp_data, 0);
      check("rst.ld_resp_tag", ld_resp_tag, 0);
      check("rst.req_addr", cache_req_addr, 0);
      check("rst.starve", dut.starve_cnt, 0);
      tick();

      // Load extraction table, minimum-latency timing on each.
      for (int i = 0; i < 9; i++) begin
         do_load(vecs[i], 5'(7 + i), $sformatf("ldvec%0d", i));
      end

      // Store with three stall cycles from the cache.
      st_req_valid = 1'b1;
      st_req_addr  = 32'h0000_2000;
      st_req_data  = 32'hDEAD_BEEF;
      st_req_size  = 2'd2;
      #1;
      check("st.ready", st_req_ready, 1);
      check("st.ld_ready", ld_req_ready, 0);
      tick();
      st_req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("st.hold%0d.valid", c), cache_req_valid, 1);
         check($sformatf("st.hold%0d.wr", c), cache_req_wr, 1);
         check($sformatf("st.hold%0d.addr", c), cache_req_addr, 32'h0000_2000);
         check($sformatf("st.hold%0d.data", c), cache_req_data, 32'hDEAD_BEEF);
         check($sformatf("st.hold%0d.size", c), cache_req_size, 2);
         cache_req_ready = (c == 3);
         tick();
      end
      cache_req_ready = 1'b0;
      #1;
      check("st.req_dropped", cache_req_valid, 0);
      tick();
      check("st.no_early_done", st_done, 0);
      cache_resp_valid = 1'b1;
      tick();
      cache_resp_valid = 1'b0;
      check("st.done", st_done, 1);
      tick();
      check("st.done_pulse_end", st_done, 0);

      // Continuous contention: four loads win, then the starving store is promoted.
      st_req_valid  = 1'b1;
      st_req_addr   = 32'h0000_0200;
      st_req_data   = 32'h1111_1111;
      st_req_size   = 2'd2;
      ld_req_valid  = 1'b1;
      ld_req_addr   = 32'h0000_0100;
      ld_req_size   = 2'd2;
      ld_req_signed = 1'b0;
      ld_req_tag    = 5'd1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("starve%0d.ld_ready", k), ld_req_ready, (k < 4));
         check($sformatf("starve%0d.st_ready", k), st_req_ready, (k == 4));
         if (k == 4) check("starve.cnt_at_promote", dut.starve_cnt, STARVE_LIMIT);
         tick();
         if (k == 4) begin
            st_req_valid = 1'b0;
            ld_req_valid = 1'b0;
         end
         #1;
         check($sformatf("starve%0d.wr", k), cache_req_wr, (k == 4));
         cache_req_ready = 1'b1;
         tick();
         cache_req_ready  = 1'b0;
         cache_resp_valid = 1'b1;
         tick();
         cache_resp_valid = 1'b0;
      end
      check("starve.cnt_cleared", dut.starve_cnt, 0);
      check("starve.st_done", st_done, 1);
      tick();

      // Flush while the load waits for its response: no result, then a store goes through.
      ld_req_valid  = 1'b1;
      ld_req_addr   = 32'h0000_8000;
      ld_req_size   = 2'd2;
      ld_req_signed = 1'b0;
      ld_req_tag    = 5'd3;
      #1;
      check("flush.ld_ready", ld_req_ready, 1);
      tick();
      ld_req_valid    = 1'b0;
      cache_req_ready = 1'b1;
      tick();
      cache_req_ready = 1'b0;
      flush           = 1'b1;
      tick();
      flush            = 1'b0;
      cache_resp_valid = 1'b1;
      cache_resp_data  = 32'h1234_5678;
      tick();
      cache_resp_valid = 1'b0;
      st_req_valid     = 1'b1;
      st_req_addr      = 32'h0000_9001;
      st_req_data      = 32'h0000_0055;
      st_req_size      = 2'd0;
      #1;
      check("flush.no_ld_resp", ld_resp_valid, 0);
      check("flush.st_ready", st_req_ready, 1);
      tick();
      st_req_valid = 1'b0;
      #1;
      check("flush.st_wr", cache_req_wr, 1);
      check("flush.st_addr", cache_req_addr, 32'h0000_9001);
      cache_req_ready = 1'b1;
      tick();
      cache_req_ready  = 1'b0;
      cache_resp_valid = 1'b1;
      tick();
      cache_resp_valid = 1'b0;
      check("flush.st_done", st_done, 1);
      check("flush.still_no_ld", ld_resp_valid, 0);
      tick();

      // Reset while a load is being issued.
      ld_req_valid  = 1'b1;
      ld_req_addr   = 32'h0000_A000;
      ld_req_size   = 2'd2;
      ld_req_tag    = 5'd9;
      tick();
      ld_req_valid = 1'b0;
      #1;
      check("rstmid.issuing", cache_req_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rstmid.req_valid", cache_req_valid, 0);
      check("rstmid.ld_resp_valid", ld_resp_valid, 0);
      check("rstmid.st_done", st_done, 0);
      check("rstmid.ld_resp_data", ld_resp_data, 0);
      check("rstmid.ld_resp_tag", ld_resp_tag, 0);
      check("rstmid.req_addr", cache_req_addr, 0);
      st_req_valid = 1'b1;
      #1;
      check("rstmid.idle_st_ready", st_req_ready, 1);
      st_req_valid = 1'b0;
      tick();

      // Randomized traffic against the reference model.
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      m_out    = 1'b0;
      m_sent   = 1'b0;
      m_sq     = 1'b0;
      m_starve = 0;
      for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
         st_req_valid  = ($urandom_range(0, 1) == 1);
         sz            = $urandom_range(0, 2);
         st_req_size   = 2'(sz);
         st_req_addr   = $urandom & ((sz == 2) ? 32'hFFFF_FFFC : (sz == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
         st_req_data   = $urandom;
         ld_req_valid  = ($urandom_range(0, 9) < 6);
         sz            = $urandom_range(0, 2);
         ld_req_size   = 2'(sz);
         ld_req_addr   = $urandom & ((sz == 2) ? 32'hFFFF_FFFC : (sz == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
         ld_req_signed = ($urandom_range(0, 1) == 1);
         ld_req_tag    = 5'($urandom_range(0, 31));
         flush         = ($urandom_range(0, 11) == 0);
         cache_req_ready  = ($urandom_range(0, 1) == 1);
         cache_resp_valid = m_out && (m_sent ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
         cache_resp_data  = $urandom;
         #1;

         ld_ok    = ld_req_valid && !flush;
         st_win   = st_req_valid && (!ld_ok || (m_starve >= STARVE_LIMIT));
         e_st_rdy = !m_out && st_win;
         e_ld_rdy = !m_out && ld_ok && !st_win;
         e_crv    = m_out && !m_sent;
         check("rnd.st_ready", st_req_ready, e_st_rdy);
         check("rnd.ld_ready", ld_req_ready, e_ld_rdy);
         check("rnd.req_valid", cache_req_valid, e_crv);
         if (e_crv) begin
            check("rnd.req_wr", cache_req_wr, m_txn.wr);
            check("rnd.req_addr", cache_req_addr, m_txn.addr);
            check("rnd.req_size", cache_req_size, m_txn.size);
            if (m_txn.wr) check("rnd.req_data", cache_req_data, m_txn.data);
         end

         e_ldv = 1'b0;
         e_std = 1'b0;
         if (!m_out) begin
            if (e_st_rdy) begin
               m_txn    = '{1'b1, st_req_addr, st_req_data, st_req_size, 1'b0, 5'd0};
               m_starve = 0;
               m_out    = 1'b1;
               m_sent   = 1'b0;
            end else if (e_ld_rdy) begin
               m_txn  = '{1'b0, ld_req_addr, 32'd0, ld_req_size, ld_req_signed, ld_req_tag};
               if (st_req_valid && m_starve < 15) m_starve++;
               m_out  = 1'b1;
               m_sent = 1'b0;
            end
         end else begin
            if (flush && !m_txn.wr) m_sq = 1'b1;
            if (!m_sent) begin
               if (cache_req_ready) m_sent = 1'b1;
            end else if (cache_resp_valid) begin
               m_out = 1'b0;
               if (m_txn.wr) begin
                  e_std = 1'b1;
               end else if (!m_sq) begin
                  e_ldv = 1'b1;
                  e_ldd = model_extract(cache_resp_data, m_txn.addr, m_txn.size, m_txn.sgn);
                  e_ldt = m_txn.tag;
               end
               m_sq = 1'b0;
            end
         end

         tick();
         check("rnd.ld_resp_valid", ld_resp_valid, e_ldv);
         check("rnd.st_done", st_done, e_std);
         if (e_ldv) begin
            check("rnd.ld_resp_data", ld_resp_data, e_ldd);
            check("rnd.ld_resp_tag", ld_resp_tag, e_ldt);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Sequences the single data-cache port between the store queue retire path (store head commit) and the load buffer miss/issue path.
- One outstanding cache transaction at a time.
- Arbitration: load priority by default, with anti-starvation promotion for stores.
- Returns load data (size/sign-extended) tagged with the load's ROB index, and acknowledges retired stores so the SQ can advance its head.

Parameters:
XLEN, 32, data/address width
TAG_W, 5, load tag width (ROB index)
STARVE_LIMIT, 4, cycles a waiting store may lose arbitration before it gets priority (1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
st_req_valid  in  1  SQ head store is resolved and committed by ROB
st_req_addr  in  XLEN  store address
st_req_data  in  XLEN  store data (LSB-aligned)
st_req_size  in  2  0=BYTE 1=HALF 2=WORD
st_req_ready  out  1  combinational accept; store transferred when valid&&ready
ld_req_valid  in  1  load request from load buffer
ld_req_addr  in  XLEN  load address
ld_req_size  in  2  0=BYTE 1=HALF 2=WORD
ld_req_signed  in  1  1=sign-extend result
ld_req_tag  in  TAG_W  ROB index of load
ld_req_ready  out  1  combinational accept
cache_req_valid  out  1  request to D-cache
cache_req_wr  out  1  1=store 0=load
cache_req_addr  out  XLEN  address
cache_req_data  out  XLEN  store data
cache_req_size  out  2  access size
cache_req_ready  in  1  cache accepts request this cycle
cache_resp_valid  in  1  cache response (loads: data; stores: write done)
cache_resp_data  in  XLEN  aligned word containing requested bytes
ld_resp_valid  out  1  registered load-result pulse to CDB
ld_resp_data  out  XLEN  extended load result
ld_resp_tag  out  TAG_W  ROB index of result
st_done  out  1  registered one-cycle store-complete pulse to SQ
flush  in  1  branch-mispredict squash

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Arbitrate; at most one of st_req_ready/ld_req_ready is high, and only in IDLE.
  - Only one requester valid -> it is granted.
  - Both valid -> store granted if starve_cnt >= STARVE_LIMIT, else load.
  - ld_req_ready forced 0 while flush=1.
  - On grant: latch addr/data/size/signed/tag/type into request regs; next state ISSUE.
- ISSUE:
  - cache_req_valid=1 with latched fields, held stable until cache_req_ready=1, then WAIT.
  - cache_resp_valid in ISSUE is ignored.
- WAIT:
  - On cache_resp_valid -> IDLE.
  - If load and not squashed: next cycle ld_resp_valid=1, ld_resp_tag=latched tag, ld_resp_data extracted from cache_resp_data.
  - If store: next cycle st_done=1.
- Minimum latency: grant cycle T, cache_req_valid T+1, response earliest T+2, result pulse T+3.
- starve_cnt (4b):
  - +1 (saturating at 15) each IDLE cycle with st_req_valid=1 and load granted.
  - Cleared on store grant.
  - Holds in ISSUE/WAIT.
- Data extraction:
  - BYTE: lane addr[1:0]*8, 8 bits.
  - HALF: lane addr[1]*16, 16 bits; addr[0]=1 is illegal and result undefined.
  - WORD: whole word.
  - Zero-extend, or sign-extend if signed.
- Flush:
  - If asserted while a load is in ISSUE or WAIT, set squash flag. The transaction still completes on the cache interface, but no ld_resp_valid is produced.
  - Squash flag clears on return to IDLE.
  - Stores are never squashed (already committed).
- Reset:
  - State=IDLE, starve_cnt=0, squash=0.
  - ld_resp_valid=0, st_done=0, cache_req_valid=0, ld_resp_data=0, ld_resp_tag=0, request regs=0.
  - Reset mid-transaction abandons it silently; the cache is reset in the same cycle.
- Outputs ld_resp_valid and st_done are single-cycle pulses.

Optional Feature:
DCACHE_ARB_PERF_EN:
- Defined: adds outputs perf_ld_cnt, perf_st_cnt, perf_promote_cnt (32b each, reset 0, wrap on overflow).
  - perf_ld_cnt and perf_st_cnt increment on load/store grant.
  - perf_promote_cnt increments on a store grant won via the starvation rule while a load was also valid.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Load only: addr=0x1003 BYTE signed tag=7, cache ready at once, resp_data=0x80FF_FF00 at T+2 -> ld_resp_valid at T+3, data=0xFFFF_FF80, tag=7.
- Store only: addr=0x2000 WORD data=0xDEADBEEF, cache_req_ready low 3 cycles -> cache_req fields held stable; st_done pulses 1 cycle after cache_resp_valid.
- Continuous load and store valid, STARVE_LIMIT=4 -> four loads granted, fifth grant is the store; starve_cnt then 0.
- Load in WAIT, flush pulse, then cache_resp_valid -> no ld_resp_valid; FSM back to IDLE; next store granted normally.
- HALF unsigned addr=0x3002, resp=0xABCD1234 -> ld_resp_data=0x0000ABCD.
- Reset asserted during ISSUE -> next cycle cache_req_valid=0, state IDLE, all outputs 0.
